// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide RAM port between instruction fetch
// and the MEM stage. It sequences byte-serial reads and writes, assembles
// read data little-endian, and lets a branch/jump flush abort a fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned IF_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    // MEM stage side
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    // RAM side
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NBYTES = DATA_W / BYTE_W;
    // counter must reach N+1 (5 for a 4-byte read)
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic [BYTE_W-1:0]   ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;
    logic                busy_q, busy_d;

    logic [CNT_W-1:0]    k_c;
    logic [CNT_W-1:0]    rd_idx_c;
    logic [CNT_W-1:0]    mem_n_c;

    // edge index within a read, and the byte index captured at this edge
    assign k_c      = cnt_q + CNT_W'(1);
    assign rd_idx_c = cnt_q - CNT_W'(1);

    // byte count requested by the MEM stage; 10 and 11 both mean a word
    always_comb begin
        mem_n_c = CNT_W'(NBYTES);
        unique case (mem_len)
            2'b00:   mem_n_c = CNT_W'(1);
            2'b01:   mem_n_c = CNT_W'(2);
            default: mem_n_c = CNT_W'(NBYTES);
        endcase
    end

    // next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    n_d     = mem_n_c;
                    wdata_d = mem_wdata;
                    rbuf_d  = '0;
                    ram_a_d = mem_addr;
                    if (mem_we) begin
                        state_d    = MEM_WR;
                        ram_dout_d = mem_wdata[BYTE_W-1:0];
                        ram_wr_d   = 1'b1;
                        cnt_d      = CNT_W'(1);
                    end else begin
                        state_d = MEM_RD;
                        cnt_d   = '0;
                    end
                end else if (if_req && !if_flush) begin
                    state_d = IF_RD;
                    addr_d  = if_addr;
                    n_d     = CNT_W'(IF_BYTES);
                    rbuf_d  = '0;
                    ram_a_d = if_addr;
                    cnt_d   = '0;
                end
            end

            IF_RD, MEM_RD: begin
                if ((state_q == IF_RD) && if_flush) begin
                    // abandon the fetch; if_data keeps its previous value
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = k_c;
                    if (k_c < n_q) begin
                        ram_a_d = addr_q + ADDR_W'(k_c);
                    end
                    // RAM data lags the address by one cycle
                    if (cnt_q != '0) begin
                        for (int unsigned b = 0; b < NBYTES; b++) begin
                            if (CNT_W'(b) == rd_idx_c) begin
                                rbuf_d[b*BYTE_W +: BYTE_W] = ram_din;
                            end
                        end
                    end
                    if (k_c == (n_q + CNT_W'(1))) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        if (state_q == IF_RD) begin
                            if_data_d = rbuf_d;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = rbuf_d;
                            mem_done_d  = 1'b1;
                        end
                    end
                end
            end

            MEM_WR: begin
                if (cnt_q < n_q) begin
                    ram_a_d  = addr_q + ADDR_W'(cnt_q);
                    ram_wr_d = 1'b1;
                    cnt_d    = k_c;
                    for (int unsigned b = 0; b < NBYTES; b++) begin
                        if (CNT_W'(b) == cnt_q) begin
                            ram_dout_d = wdata_q[b*BYTE_W +: BYTE_W];
                        end
                    end
                end else begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end
            end

            DONE: begin
                // one-cycle completion slot; requests are not sampled here
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            busy_q      <= busy_d;
        end
    end

    assign if_data   = if_data_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign ram_dout  = ram_dout_q;
    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: byte RAM model, a table of transfers with
// hand-computed results and latencies, and directed multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(32), .IF_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_data   (if_data),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte RAM with one-cycle read latency, indexed by the low 14 address bits
    logic [7:0] ram [0:16383];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16384; i++) ram[i] <= 8'h00;
            ram[14'h0100] <= 8'h13;
            ram[14'h2000] <= 8'hF0;
            ram[14'h0040] <= 8'hEF; ram[14'h0041] <= 8'hBE;
            ram[14'h0042] <= 8'hAD; ram[14'h0043] <= 8'hDE;
            ram[14'h0080] <= 8'h01; ram[14'h0081] <= 8'h02;
            ram[14'h0082] <= 8'h03; ram[14'h0083] <= 8'h04;
            ram[14'h3FFE] <= 8'h11; ram[14'h3FFF] <= 8'h22;
            ram[14'h0000] <= 8'h33; ram[14'h0001] <= 8'h44;
            ram_din <= 8'h00;
        end else begin
            if (ram_wr) ram[ram_a[13:0]] <= ram_dout;
            ram_din <= ram[ram_a[13:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } txn_t;

    txn_t        tbl [10];
    logic [31:0] last_if;
    logic [31:0] last_mem;

    // one transfer from an idle arbiter; checks latency, data and return to idle
    task automatic run_txn(input int id, input txn_t t);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 0;
        @(negedge clk);
        if (t.is_mem) begin
            mem_req   = 1'b1;
            mem_we    = t.we;
            mem_len   = t.len;
            mem_addr  = t.addr;
            mem_wdata = t.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = t.addr;
        end
        for (int e = 0; e < 20 && !seen; e++) begin
            @(posedge clk); #1;
            if (t.is_mem ? mem_done : if_done) begin
                seen = 1;
                lat  = e;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        check($sformatf("txn%0d latency", id), 32'(lat), 32'(t.lat));
        if (t.is_mem) begin
            if (!t.we) begin
                last_mem = t.exp;
            end
            check($sformatf("txn%0d mem_rdata", id), mem_rdata, last_mem);
            check($sformatf("txn%0d if_data held", id), if_data, last_if);
        end else begin
            last_if = t.exp;
            check($sformatf("txn%0d if_data", id), if_data, last_if);
            check($sformatf("txn%0d mem_rdata held", id), mem_rdata, last_mem);
        end
        @(posedge clk); #1;
        check($sformatf("txn%0d idle busy", id), 32'(busy), 32'd0);
        check($sformatf("txn%0d done cleared", id), 32'({if_done, mem_done}), 32'd0);
    endtask

    initial begin
        int md;
        int id;
        int done_cnt;
        logic [7:0] exp_b [4];

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_len   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        last_if   = '0;
        last_mem  = '0;

        //          is_mem we len     addr          wdata         exp           lat
        tbl[0] = '{1'b0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,        32'h0000_0013, 5};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 32'h0000_2000, 32'h0,        32'h0000_00F0, 2};
        tbl[2] = '{1'b1, 1'b1, 2'b10, 32'h0000_0030, 32'hAABBCCDD, 32'h0,         4};
        tbl[3] = '{1'b1, 1'b0, 2'b10, 32'h0000_0030, 32'h0,        32'hAABBCCDD, 5};
        tbl[4] = '{1'b1, 1'b0, 2'b01, 32'h0000_0031, 32'h0,        32'h0000_BBCC, 3};
        tbl[5] = '{1'b1, 1'b0, 2'b00, 32'h0000_0033, 32'h0,        32'h0000_00AA, 2};
        tbl[6] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'h0,        32'h4433_2211, 5};
        tbl[7] = '{1'b1, 1'b1, 2'b01, 32'h0000_0500, 32'h12345678, 32'h0,         2};
        tbl[8] = '{1'b1, 1'b0, 2'b11, 32'h0000_0500, 32'h0,        32'h0000_5678, 5};
        tbl[9] = '{1'b0, 1'b0, 2'b00, 32'h0000_0030, 32'h0,        32'hAABB_CCDD, 5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset ram_a",     ram_a,     32'h0);
        check("reset ram_dout",  32'(ram_dout), 32'h0);
        check("reset ram_wr",    32'(ram_wr), 32'h0);
        check("reset if_data",   if_data,   32'h0);
        check("reset mem_rdata", mem_rdata, 32'h0);
        check("reset dones",     32'({if_done, mem_done}), 32'h0);
        check("reset busy",      32'(busy), 32'h0);

        // simultaneous requests: MEM load wins, fetch follows after DONE + IDLE
        @(negedge clk);
        if_req   = 1'b1;
        if_addr  = 32'h0000_0100;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_len  = 2'b00;
        mem_addr = 32'h0000_2000;
        md = -1;
        id = -1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            if (mem_done) begin
                md = e;
                mem_req = 1'b0;
                check("arb mem_rdata", mem_rdata, 32'h0000_00F0);
            end
            if (if_done) begin
                id = e;
                if_req = 1'b0;
                check("arb if_data", if_data, 32'h0000_0013);
            end
            if (e == 0) check("arb mem first ram_a", ram_a, 32'h0000_2000);
            if (e == 3) check("arb idle gap busy", 32'(busy), 32'd0);
            if (e == 4) check("arb if accepted ram_a", ram_a, 32'h0000_0100);
        end
        check("arb mem_done edge", 32'(md), 32'd2);
        check("arb if_done edge", 32'(id), 32'd9);
        last_if  = 32'h0000_0013;
        last_mem = 32'h0000_00F0;

        for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

        // store byte sequence on the RAM port
        exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_len   = 2'b10;
        mem_addr  = 32'h0000_0030;
        mem_wdata = 32'hAABBCCDD;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("st E%0d ram_wr", k), 32'(ram_wr), 32'd1);
            check($sformatf("st E%0d ram_a", k), ram_a, 32'h30 + 32'(k));
            check($sformatf("st E%0d ram_dout", k), 32'(ram_dout), 32'(exp_b[k]));
        end
        @(posedge clk); #1;
        check("st E4 mem_done", 32'(mem_done), 32'd1);
        check("st E4 ram_wr", 32'(ram_wr), 32'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        @(posedge clk); #1;

        // flush aborts a fetch; the next fetch completes normally
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if_flush = 1'b1;
        @(posedge clk); #1;
        check("flush busy", 32'(busy), 32'd0);
        check("flush no if_done", 32'(if_done), 32'd0);
        if_req   = 1'b0;
        if_flush = 1'b0;
        @(posedge clk); #1;
        check("flush E3 busy", 32'(busy), 32'd0);
        check("flush E3 no if_done", 32'(if_done), 32'd0);
        check("flush if_data kept", if_data, last_if);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        id = -1;
        for (int e = 0; e < 12 && id < 0; e++) begin
            @(posedge clk); #1;
            if (e == 0) check("refetch ram_a", ram_a, 32'h0000_0080);
            if (if_done) id = e;
        end
        if_req = 1'b0;
        check("refetch latency", 32'(id), 32'd5);
        check("refetch if_data", if_data, 32'h0403_0201);
        last_if = 32'h0403_0201;
        @(posedge clk); #1;

        // address wrap across the top of the address space
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'hFFFF_FFFE;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("wrap ram_a %0d", k), ram_a, 32'hFFFF_FFFE + 32'(k));
        end
        id = -1;
        for (int e = 4; e < 12 && id < 0; e++) begin
            @(posedge clk); #1;
            if (if_done) id = e;
        end
        if_req = 1'b0;
        check("wrap latency", 32'(id), 32'd5);
        check("wrap if_data", if_data, 32'h4433_2211);
        @(posedge clk); #1;

        // reset during a store abandons it
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_len   = 2'b10;
        mem_addr  = 32'h0000_0600;
        mem_wdata = 32'h0102_0304;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst pre ram_wr", 32'(ram_wr), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst ram_wr", 32'(ram_wr), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst mem_done", 32'(mem_done), 32'd0);
        check("rst ram_a", ram_a, 32'h0);
        check("rst ram_dout", 32'(ram_dout), 32'h0);
        check("rst if_data", if_data, 32'h0);
        check("rst mem_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (mem_done || ram_wr || busy) done_cnt++;
        end
        check("rst no later activity", 32'(done_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 8-bit RAM port between instruction fetch (IF) and the MEM stage.
- Sequences the byte-serial transfers on that port: 4-byte instruction reads, and 1/2/4-byte data loads and stores.
- Assembles read bytes little-endian. Aborts an in-flight fetch on a branch/jump flush.
- Sits between the IF/ID fetch logic, the MEM stage and the external RAM.

Parameters:
- ADDR_W, 32, width of all byte addresses
- IF_BYTES, 4, bytes per instruction fetch

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_done or flush
- if_addr  in  ADDR_W  fetch byte address; stable while if_req high
- if_flush  in  1  jump/branch flush; aborts fetch
- if_data  out  32  fetched instruction
- if_done  out  1  one-cycle fetch-complete pulse
- mem_req  in  1  data request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  32  store data; byte k is bits [8k+7:8k]
- mem_rdata  out  32  load data, zero-extended
- mem_done  out  1  one-cycle data-complete pulse
- ram_din  in  8  RAM read byte
- ram_dout  out  8  RAM write byte
- ram_a  out  ADDR_W  RAM address
- ram_wr  out  1  RAM write enable
- busy  out  1  high in any state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; ram_a = 0; ram_dout = 0; ram_wr = 0; if_data = 0; mem_rdata = 0; if_done = 0; mem_done = 0; busy = 0; byte counter = 0.
- Reset mid-transaction abandons the transfer: no done pulse, and ram_wr = 0 from the next cycle.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Arbitration happens only in IDLE, sampled at the clock edge:
  - mem_req wins over if_req (strict priority).
  - if_req together with if_flush at the same edge is ignored.
  - There is no preemption once a transfer has started.
- Transfer setup at acceptance edge E0:
  - The address, length and write data are latched.
  - N = IF_BYTES for IF, otherwise from mem_len.
  - ram_a <= addr.
- Address rules:
  - Byte k uses address addr+k, with ADDR_W-bit wrap (0xFFFFFFFF+1 = 0).
  - No alignment checks.
- Read timing (IF_RD / MEM_RD):
  - ram_a = addr+k is presented during the cycle after edge Ek, for k = 0..N-1.
  - RAM has 1-cycle read latency, so the byte for addr+k is valid on ram_din in the cycle after E(k+1) and is captured at edge E(k+2).
  - At E(N+1) the last byte is captured, the result is written into if_data or mem_rdata, the done pulse is raised, and the state goes to DONE.
  - Fetch: acceptance to done-high is 5 edges.
  - 1-byte load: acceptance to done-high is 2 edges.
- Write timing (MEM_WR):
  - At edge Ek, for k = 0..N-1: ram_a <= addr+k, ram_dout <= wdata byte k, ram_wr <= 1.
  - At EN: ram_wr <= 0, mem_done <= 1, state goes to DONE.
- DONE state:
  - Lasts exactly one cycle, during which the done pulse is high.
  - Requests are ignored in DONE, so a requester still holding req during its done cycle is not re-accepted.
  - Then the state returns to IDLE.
  - Back-to-back transfers therefore always have one DONE cycle plus one IDLE arbitration edge between them.
- Load results:
  - mem_rdata upper bytes beyond N are 0; sign extension is the MEM stage's job.
  - if_data and mem_rdata hold their value until the next completion of the same type.
- Flush:
  - if_flush high at any edge in IF_RD aborts the fetch: state returns to IDLE, no if_done, if_data unchanged, ram_wr stays 0.
  - if_flush during MEM_RD, MEM_WR or DONE has no effect.
  - A new if_req may be accepted at the edge after the flush edge.
- ram_wr is never high outside MEM_WR.
- busy = (state != IDLE).

Test Plan:
- Reset, then if_req with if_addr = 0x100 and RAM bytes 13,00,00,00 at 0x100..0x103 → ram_a steps 0x100..0x103; if_done pulses 5 edges after acceptance; if_data = 0x00000013.
- if_req and mem_req (load, len = 00, addr = 0x2000, byte 0xF0) raised in the same cycle → MEM granted first; mem_rdata = 0x000000F0; mem_done pulses after 2 edges; IF accepted only after the DONE and IDLE cycles.
- Store, len = 10, addr = 0x30, wdata = 0xAABBCCDD → ram_wr is high for 4 cycles writing DD, CC, BB, AA to 0x30..0x33; mem_done pulses at E4, and ram_wr = 0 in that cycle.
- Fetch at 0x40 with if_flush pulsed at E2 → no if_done; busy = 0 at E3; a new fetch at 0x80 is accepted at E4 and completes with correct data.
- Fetch at 0xFFFFFFFE → ram_a sequence is FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rst asserted at E2 of a 4-byte store → ram_wr = 0 and busy = 0 after that edge; no mem_done; outputs equal their reset values.
